// File: rtl/lookup_cfg_ctrl.sv
// rtl/lookup_cfg_ctrl.sv - write sequencer for one stage's TCAM and action RAM
// Holds keys, drains in-flight lookups, then writes the action RAM before the TCAM.
module lookup_cfg_ctrl #(
  parameter int STAGE        = 0,
  parameter int KEY_LEN      = 197,
  parameter int ACT_LEN      = 25,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [3:0]              cfg_addr,
  input  logic [KEY_LEN-1:0]      cfg_key,
  input  logic [KEY_LEN-1:0]      cfg_mask,
  input  logic [ACT_LEN*25-1:0]   cfg_action,
  output logic                    cfg_done,
  output logic                    cfg_err,
  input  logic                    key_valid_in,
  output logic                    key_ready,
  output logic                    key_valid_out,
  input  logic                    action_valid_in,
  output logic                    cam_we,
  output logic [3:0]              cam_wr_addr,
  output logic [KEY_LEN-1:0]      cam_din,
  output logic [KEY_LEN-1:0]      cam_data_mask,
  input  logic                    cam_busy,
  output logic                    act_we,
  output logic [3:0]              act_addr,
  output logic [ACT_LEN*25-1:0]   act_din,
  output logic [15:0]             entry_valid
);

  if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 255 || STAGE < 0) begin : g_bad_params
    $error("lookup_cfg_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ACT_WR,
    S_CAM_WR,
    S_CAM_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              addr_q, addr_d;
  logic [KEY_LEN-1:0]      key_q, key_d;
  logic [KEY_LEN-1:0]      mask_q, mask_d;
  logic [ACT_LEN*25-1:0]   act_q, act_d;
  logic                    err_q, err_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              inflight_q, inflight_d;
  logic [15:0]             valid_q, valid_d;
  logic [8:0]              cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      key_q      <= '0;
      mask_q     <= '0;
      act_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      inflight_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      key_q      <= key_d;
      mask_q     <= mask_d;
      act_q      <= act_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    key_d   = key_q;
    mask_d  = mask_q;
    act_d   = act_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          addr_d  = cfg_addr;
          key_d   = cfg_key;
          mask_d  = cfg_mask;
          act_d   = cfg_action;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight_q == 3'd0) state_d = S_ACT_WR;
      end
      S_ACT_WR: state_d = S_CAM_WR;
      S_CAM_WR: begin
        cnt_d   = '0;
        state_d = S_CAM_WAIT;
      end
      S_CAM_WAIT: begin
        if (!cam_busy) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc[7:0];
          if (cnt_inc == 9'(BUSY_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A timed-out write leaves the TCAM entry undefined, so it is marked invalid.
        valid_d[addr_q] = !err_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (key_valid_out && !action_valid_in && inflight_q != 3'd7) begin
      inflight_d = inflight_q + 3'd1;
    end else if (!key_valid_out && action_valid_in && inflight_q != 3'd0) begin
      inflight_d = inflight_q - 3'd1;
    end
  end

  assign cfg_ready     = (state_q == S_IDLE);
  assign key_ready     = (state_q == S_IDLE);
  assign key_valid_out = key_valid_in & key_ready;

  assign act_we        = (state_q == S_ACT_WR);
  assign act_addr      = act_we ? addr_q : '0;
  assign act_din       = act_we ? act_q : '0;

  assign cam_we        = (state_q == S_CAM_WR);
  assign cam_wr_addr   = cam_we ? addr_q : '0;
  assign cam_din       = cam_we ? key_q : '0;
  assign cam_data_mask = cam_we ? mask_q : '0;

  assign cfg_done      = (state_q == S_DONE);
  assign cfg_err       = cfg_done & err_q;
  assign entry_valid   = valid_q;

endmodule

// File: tb/tb_lookup_cfg_ctrl.sv
// tb/tb_lookup_cfg_ctrl.sv - bench for lookup_cfg_ctrl
// Timestamp-schedule model plus directed latency checks.
module tb_lookup_cfg_ctrl;

  localparam int KEY_LEN = 197;
  localparam int ACT_LEN = 25;
  localparam int AW      = ACT_LEN * 25;
  localparam int BT      = 64;
  localparam int CW      = 640;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [3:0]      cfg_addr;
  logic [KEY_LEN-1:0] cfg_key;
  logic [KEY_LEN-1:0] cfg_mask;
  logic [AW-1:0]   cfg_action;
  logic            cfg_done;
  logic            cfg_err;
  logic            key_valid_in;
  logic            key_ready;
  logic            key_valid_out;
  logic            action_valid_in;
  logic            cam_we;
  logic [3:0]      cam_wr_addr;
  logic [KEY_LEN-1:0] cam_din;
  logic [KEY_LEN-1:0] cam_data_mask;
  logic            cam_busy;
  logic            act_we;
  logic [3:0]      act_addr;
  logic [AW-1:0]   act_din;
  logic [15:0]     entry_valid;

  lookup_cfg_ctrl #(
    .STAGE(0), .KEY_LEN(KEY_LEN), .ACT_LEN(ACT_LEN), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_key(cfg_key), .cfg_mask(cfg_mask), .cfg_action(cfg_action),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .key_valid_in(key_valid_in), .key_ready(key_ready), .key_valid_out(key_valid_out),
    .action_valid_in(action_valid_in),
    .cam_we(cam_we), .cam_wr_addr(cam_wr_addr), .cam_din(cam_din),
    .cam_data_mask(cam_data_mask), .cam_busy(cam_busy),
    .act_we(act_we), .act_addr(act_addr), .act_din(act_din),
    .entry_valid(entry_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Observations of DUT events, used by the directed latency checks
  int act_seen  = -1;
  int cam_seen  = -1;
  int done_seen = -1;
  logic [3:0] cam_addr_seen;
  logic       err_seen;

  // Model: a command is a set of timestamps; outputs follow from where cycle c falls
  bit               model_ok = 0;
  bit               m_active;
  int               m_act_at;
  int               m_done_at;
  bit               m_err;
  int               m_inflight;
  logic [15:0]      m_valid;
  logic [3:0]       m_addr;
  logic [KEY_LEN-1:0] m_key;
  logic [KEY_LEN-1:0] m_mask;
  logic [AW-1:0]    m_act;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit e_act, e_cam, e_done, kacc;
        int inf_now, k;
        e_act  = m_active && (m_act_at == cyc);
        e_cam  = m_active && (m_act_at >= 0) && (cyc == m_act_at + 1);
        e_done = m_active && (cyc == m_done_at);
        if (model_ok) begin
          chk("cfg_ready", CW'(cfg_ready), CW'(!m_active));
          chk("key_ready", CW'(key_ready), CW'(!m_active));
          chk("key_valid_out", CW'(key_valid_out), CW'(key_valid_in && !m_active));
          chk("act_we", CW'(act_we), CW'(e_act));
          chk("act_addr", CW'(act_addr), e_act ? CW'(m_addr) : '0);
          chk("act_din", CW'(act_din), e_act ? CW'(m_act) : '0);
          chk("cam_we", CW'(cam_we), CW'(e_cam));
          chk("cam_wr_addr", CW'(cam_wr_addr), e_cam ? CW'(m_addr) : '0);
          chk("cam_din", CW'(cam_din), e_cam ? CW'(m_key) : '0);
          chk("cam_data_mask", CW'(cam_data_mask), e_cam ? CW'(m_mask) : '0);
          chk("cfg_done", CW'(cfg_done), CW'(e_done));
          chk("cfg_err", CW'(cfg_err), CW'(e_done && m_err));
          chk("entry_valid", CW'(entry_valid), CW'(m_valid));
        end
        if (act_we === 1'b1) act_seen = cyc;
        if (cam_we === 1'b1) begin cam_seen = cyc; cam_addr_seen = cam_wr_addr; end
        if (cfg_done === 1'b1) begin done_seen = cyc; err_seen = cfg_err; end
        if (!rst_n) begin
          m_active = 0; m_inflight = 0; m_valid = '0;
          m_act_at = -1; m_done_at = -1; m_err = 0;
          model_ok = 1;
        end else if (model_ok) begin
          inf_now = m_inflight;
          kacc = key_valid_in && !m_active;
          if (kacc && !action_valid_in) m_inflight = (m_inflight < 7) ? m_inflight + 1 : 7;
          else if (!kacc && action_valid_in) m_inflight = (m_inflight > 0) ? m_inflight - 1 : 0;
          if (!m_active) begin
            if (cfg_valid) begin
              m_active = 1; m_addr = cfg_addr; m_key = cfg_key; m_mask = cfg_mask;
              m_act = cfg_action; m_act_at = -1; m_done_at = -1;
            end
          end else if (m_done_at == cyc) begin
            m_valid[m_addr] = !m_err;
            m_active = 0;
          end else if (m_act_at < 0) begin
            if (inf_now == 0) m_act_at = cyc + 1;
          end else if (m_done_at < 0 && cyc >= m_act_at + 2) begin
            k = cyc - (m_act_at + 2) + 1;
            if (!cam_busy) begin m_done_at = cyc + 1; m_err = 0; end
            else if (k == BT) begin m_done_at = cyc + 1; m_err = 1; end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] a, input logic [31:0] s);
    logic [223:0] kt;
    logic [639:0] at;
    kt = {7{s}};
    at = {20{s ^ 32'h5A5A_A5A5}};
    cfg_addr   = a;
    cfg_key    = kt[KEY_LEN-1:0];
    cfg_mask   = ~kt[KEY_LEN-1:0] & {KEY_LEN{s[0]}};
    cfg_action = at[AW-1:0];
  endtask

  task automatic wait_done(input int n, input int limit);
    int cnt;
    cnt = 0;
    while (done_seen < n && cnt < limit) begin
      step();
      cnt++;
    end
    chk("done_within_budget", CW'(done_seen >= n), CW'(1));
  endtask

  int n;

  initial begin
    rst_n = 0; cfg_valid = 0; cfg_addr = '0; cfg_key = '0; cfg_mask = '0;
    cfg_action = '0; key_valid_in = 0; action_valid_in = 0; cam_busy = 0;
    step(); step();
    chk("rst_cfg_ready", CW'(cfg_ready), CW'(1));
    chk("rst_key_ready", CW'(key_ready), CW'(1));
    chk("rst_entry_valid", CW'(entry_valid), CW'(0));
    chk("rst_cfg_done", CW'(cfg_done), CW'(0));
    rst_n = 1;
    step(); step();

    // Idle write to entry 3
    set_cmd(4'd3, 32'hDEAD_BEEF); cfg_valid = 1; n = cyc;
    step(); cfg_valid = 0;
    wait_done(n, 100);
    chk("idle_act_lat", CW'(act_seen - n), CW'(2));
    chk("idle_cam_lat", CW'(cam_seen - n), CW'(3));
    chk("idle_cam_addr", CW'(cam_addr_seen), CW'(3));
    chk("idle_done_lat", CW'(done_seen - n), CW'(5));
    chk("idle_err", CW'(err_seen), CW'(0));
    chk("idle_entry_valid", CW'(entry_valid), CW'(16'h0008));
    step(); step();

    // Drain: key one cycle before the command, result four cycles after
    key_valid_in = 1; step();
    key_valid_in = 0;
    set_cmd(4'd9, 32'h1234_5671); cfg_valid = 1; n = cyc;
    step(); cfg_valid = 0; key_valid_in = 1; #1;
    chk("drain_key_ready", CW'(key_ready), CW'(0));
    chk("drain_kvo_held", CW'(key_valid_out), CW'(0));
    step(); step(); step(); action_valid_in = 1;
    step(); action_valid_in = 0;
    step(); key_valid_in = 0;
    wait_done(n, 100);
    chk("drain_act_lat", CW'(act_seen - n), CW'(6));
    chk("drain_entry_valid", CW'(entry_valid), CW'(16'h0208));
    step();

    // Key and command in the same cycle
    set_cmd(4'd0, 32'h0F0F_F0F0); cfg_valid = 1; key_valid_in = 1; n = cyc; #1;
    chk("simul_kvo", CW'(key_valid_out), CW'(1));
    step(); cfg_valid = 0; key_valid_in = 0;
    repeat (8) step();
    chk("simul_no_act_yet", CW'(act_seen >= n), CW'(0));
    action_valid_in = 1;
    step(); action_valid_in = 0;
    wait_done(n, 100);
    chk("simul_act_lat", CW'(act_seen - n), CW'(11));
    step();

    // Busy stretch of 10 cycles after cam_we
    set_cmd(4'd5, 32'hCAFE_0001); cfg_valid = 1; n = cyc;
    step(); cfg_valid = 0;
    step(); step(); step(); cam_busy = 1;
    repeat (10) step();
    cam_busy = 0;
    wait_done(n, 100);
    chk("busy_done_lat", CW'(done_seen - n), CW'(15));
    chk("busy_err", CW'(err_seen), CW'(0));
    chk("busy_entry_valid", CW'(entry_valid), CW'(16'h0229));
    step();

    // Timeout rewriting entry 3
    set_cmd(4'd3, 32'hBAD0_0BAD); cfg_valid = 1; cam_busy = 1; n = cyc;
    step(); cfg_valid = 0;
    wait_done(n, 200);
    cam_busy = 0;
    chk("tmo_done_lat", CW'(done_seen - n), CW'(68));
    chk("tmo_err", CW'(err_seen), CW'(1));
    chk("tmo_entry_valid", CW'(entry_valid), CW'(16'h0221));
    step();

    // Reset while in CAM_WR
    set_cmd(4'd7, 32'h7777_0007); cfg_valid = 1; n = cyc;
    step(); cfg_valid = 0;
    step();
    step(); rst_n = 0; #1;
    chk("rstmid_cam_we", CW'(cam_we), CW'(1));
    step(); rst_n = 1;
    chk("rstmid_entry_valid", CW'(entry_valid), CW'(0));
    chk("rstmid_cfg_ready", CW'(cfg_ready), CW'(1));
    chk("rstmid_cam_we_off", CW'(cam_we), CW'(0));
    chk("rstmid_cfg_done", CW'(cfg_done), CW'(0));
    step();
    set_cmd(4'd1, 32'h0000_1111); cfg_valid = 1; n = cyc;
    step(); cfg_valid = 0;
    wait_done(n, 100);
    chk("post_rst_done_lat", CW'(done_seen - n), CW'(5));
    chk("post_rst_entry_valid", CW'(entry_valid), CW'(16'h0002));
    step();

    // Inflight saturation: underflow attempts in IDLE, then nine keys
    action_valid_in = 1; step(); step(); action_valid_in = 0;
    key_valid_in = 1; repeat (9) step(); key_valid_in = 0;
    set_cmd(4'd15, 32'hF00D_F00D); cfg_valid = 1; n = cyc;
    step(); cfg_valid = 0; action_valid_in = 1;
    repeat (7) step();
    action_valid_in = 0;
    wait_done(n, 100);
    chk("sat_act_lat", CW'(act_seen - n), CW'(9));
    chk("sat_entry_valid", CW'(entry_valid), CW'(16'h8002));
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lookup_cfg_ctrl.md
# lookup_cfg_ctrl

Control-plane sequencer that owns the write side of one stage's lookup resources: the 16-entry TCAM and the 16-deep, 625-bit action RAM. It accepts one configuration command at a time and holds new keys at the key-extractor → lookup-engine boundary. It drains the in-flight lookup, then writes the action RAM before the TCAM, so a hit never returns a stale action. It reports completion or timeout, and keeps a per-entry valid bitmap.

## Interface
- STAGE, 0, stage index, informational only
- KEY_LEN, 197, TCAM key/mask width
- ACT_LEN, 25, width of one action slot; the action word is ACT_LEN*25
- BUSY_TIMEOUT, 64, maximum cycles to wait for TCAM busy to drop (≤255)

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- cfg_valid  in  1  command valid
- cfg_ready  out  1  command accepted when cfg_valid & cfg_ready
- cfg_addr  in  4  entry index
- cfg_key  in  KEY_LEN  TCAM match data
- cfg_mask  in  KEY_LEN  TCAM data mask (1 = don't care)
- cfg_action  in  ACT_LEN*25  action word
- cfg_done  out  1  one-cycle completion pulse
- cfg_err  out  1  valid with cfg_done; 1 = TCAM busy timeout
- key_valid_in  in  1  key valid from key extractor
- key_ready  out  1  low while holding keys
- key_valid_out  out  1  key_valid_in & key_ready, to the lookup engine
- action_valid_in  in  1  lookup-engine result strobe, used for drain tracking
- cam_we  out  1  TCAM write enable
- cam_wr_addr  out  4  TCAM write address
- cam_din  out  KEY_LEN  TCAM write data
- cam_data_mask  out  KEY_LEN  TCAM write mask
- cam_busy  in  1  TCAM write in progress
- act_we  out  1  action RAM write enable
- act_addr  out  4  action RAM write address
- act_din  out  ACT_LEN*25  action RAM write data
- entry_valid  out  16  bit i set after a successful write of entry i

## Operation
- States: IDLE, DRAIN, ACT_WR, CAM_WR, CAM_WAIT, DONE.
- IDLE:
  - cfg_ready = 1 and key_ready = 1.
  - On accept, cfg_addr, cfg_key, cfg_mask and cfg_action are latched into command registers, and the FSM moves to DRAIN.
- DRAIN:
  - key_ready = 0.
  - Stay while inflight ≠ 0.
  - When inflight = 0, go to ACT_WR.
- ACT_WR:
  - act_we = 1 for exactly one cycle, with act_addr and act_din taken from the command registers.
  - Then go to CAM_WR.
- CAM_WR:
  - cam_we = 1 for exactly one cycle, with cam_wr_addr, cam_din and cam_data_mask taken from the command registers.
  - The timeout counter clears. Then go to CAM_WAIT.
- CAM_WAIT:
  - Minimum residency is one cycle.
  - When cam_busy = 0, go to DONE with err = 0.
  - Otherwise the counter increments. When it reaches BUSY_TIMEOUT, go to DONE with err = 1.
- DONE:
  - cfg_done = 1 and cfg_err = err.
  - If err = 0, set entry_valid[addr]. If err = 1, clear entry_valid[addr].
  - Then go to IDLE.
- inflight counter (3 bits):
  - +1 on key_valid_out and −1 on action_valid_in; both in the same cycle leaves it unchanged.
  - Saturates at 7 and 0.
- key_ready = 1 only in IDLE. Keys accepted in the same cycle as a command are counted into inflight.
- Write-path outputs are 0 outside their active states.
- key_valid_out is combinational from key_valid_in and key_ready. All other outputs are registered or decoded from the state register.

## Timing
- Reset values, for any state at rst_n = 0:
  - State = IDLE; cfg_ready = 1 (IDLE decode); key_ready = 1.
  - cfg_done, cfg_err, cam_we, act_we = 0.
  - All address and data outputs, entry_valid, inflight and the timeout counter = 0.
- Reset during any state abandons the command. Any write already issued is not retried.
- With command accept at cycle N and inflight = 0:
  - DRAIN at N+1.
  - act_we at N+2.
  - cam_we at N+3.
  - CAM_WAIT from N+4.
  - cfg_done at the cycle after cam_busy is first sampled low in CAM_WAIT. That is N+5 at the earliest, when cam_busy is low at N+4.
- With a lookup outstanding, DRAIN extends until the cycle after inflight reaches 0.
- cfg_ready is 0 from N+1 until the cycle after DONE. Back-to-back commands are therefore accepted at the earliest at cfg_done + 1.
- key_ready deasserts at N+1 and reasserts in the first IDLE cycle after DONE.
- A timeout fires BUSY_TIMEOUT cycles after entering CAM_WAIT with cam_busy continuously high.

## Test plan
- Idle write: inflight = 0, addr = 3, cam_busy low throughout.
  - act_we at N+2, cam_we at N+3 (cam_wr_addr = 3), cfg_done = 1 and cfg_err = 0 at N+5.
  - entry_valid = 16'h0008.
- Drain: key accepted at N−1, action_valid_in at N+4, command accepted at N.
  - key_ready = 0 from N+1 and key_valid_out stays 0 while held.
  - act_we at N+6.
- Simultaneous: key_valid_in and cfg_valid both high at N.
  - key_valid_out = 1 at N, so inflight = 1.
  - DRAIN waits for action_valid_in before act_we.
- Busy stretch: cam_busy held high for 10 cycles after cam_we.
  - cfg_done one cycle after busy drops, cfg_err = 0.
- Timeout: cam_busy stuck high, BUSY_TIMEOUT = 64.
  - cfg_done with cfg_err = 1 after 64 CAM_WAIT cycles; entry_valid[addr] = 0.
- Reset mid-op: rst_n = 0 in CAM_WR.
  - Next cycle all outputs are at reset values, entry_valid = 0, and cfg_ready = 1 after release.
